step_control: RTL and testbench
===============================

STEP_CONTROL -- requirements
Module: step_control

Interface
REQ-001 Parameter DebounceVal, default 1000000, number of stable Clk cycles StepBtn needs before its debounced level changes (10 ms at 100 MHz); legal range 1 to 2^24-1.
REQ-002 Clk  input  1  100 MHz board clock; all state changes on the rising edge.
REQ-003 Rst  input  1  asynchronous, active-low reset.
REQ-004 SlowClk  input  1  divided 1 Hz square wave from the clock divider, asynchronous to Clk.
REQ-005 RunSw  input  1  level; 1 requests free-run mode.
REQ-006 StepBtn  input  1  raw push-button, bouncy, asynchronous.
REQ-007 HaltReq  input  1  processor halt request, synchronous to Clk.
REQ-008 CpuEn  output  1  processor clock-enable, one Clk cycle wide per granted step.
REQ-009 Mode  output  2  current state: 00 IDLE, 01 RUN, 10 ARMED, 11 HALTED.
REQ-010 CycleCnt  output  32  count of CpuEn pulses issued.

Function
REQ-011 SlowClk SHALL pass through a 2-flop synchronizer, then a previous-value register; a tick is synchronized-high AND previous-low.
REQ-012 CpuEn SHALL be registered and asserted exactly 3 Clk cycles after the first Clk edge that samples SlowClk high, when the state grants it.
REQ-013 StepBtn SHALL pass through a 2-flop synchronizer; the debounced level updates only after the synchronized value has differed from it for DebounceVal consecutive cycles; any mismatch-free cycle clears the counter.
REQ-014 Step event = debounced level 0->1 transition, one cycle wide; held button generates one event only.
REQ-015 IDLE: CpuEn=0; HaltReq -> HALTED; else RunSw=1 -> RUN; else step event -> ARMED.
REQ-016 RUN: CpuEn pulses on every tick; HaltReq -> HALTED (no pulse that cycle); else RunSw=0 -> IDLE; step events ignored.
REQ-017 ARMED: on next tick issue one CpuEn pulse and -> IDLE; HaltReq -> HALTED with no pulse; RunSw=1 -> RUN, where the pending tick is issued as a RUN pulse; further step events ignored.
REQ-018 HALTED: CpuEn=0; -> IDLE only when RunSw=0 and HaltReq=0 in the same cycle.
REQ-019 Priority in every state: HaltReq > RunSw > step event > tick.
REQ-020 Tick and state-leaving condition in same cycle: pulse granted only if current state grants it and HaltReq=0.
REQ-021 CycleCnt SHALL increment by 1 in the cycle CpuEn is asserted and saturate at 0xFFFFFFFF (no wrap).
REQ-022 Mode SHALL reflect the registered state, no combinational path from inputs.

Reset
REQ-023 Rst=0 SHALL immediately force state IDLE, CpuEn=0, Mode=00, CycleCnt=0, all synchronizer, previous-value and debounce registers and counters to 0.
REQ-024 Reset asserted mid-ARMED or mid-pulse SHALL drop CpuEn the same instant and discard the pending step.
REQ-025 After Rst deassert, a SlowClk already high SHALL NOT generate a tick until it goes low and high again, which the zeroed previous-value register guarantees only after sync fills; the implementation SHALL load the previous register with the synchronized value during the first 2 cycles after reset.

Configuration
REQ-026 Macro STEP_CYCLE_COUNT_EN: defined -> CycleCnt implemented per REQ-021; undefined -> counter logic absent and CycleCnt tied to 0.

Verification
REQ-027 DebounceVal=4, RunSw=0, press StepBtn clean for 10 cycles, then SlowClk 0->1 -> Mode 00->10, exactly one CpuEn pulse 3 cycles after SlowClk sampled high, Mode returns 00, CycleCnt=1.
REQ-028 StepBtn toggling every 2 cycles for 20 cycles, DebounceVal=4 -> no step event, Mode stays 00.
REQ-029 RunSw=1, 5 SlowClk rising edges -> 5 CpuEn pulses, CycleCnt=5; HaltReq=1 coincident with 6th tick -> no pulse, Mode=11, CycleCnt=5.
REQ-030 Mode=11, RunSw=0 and HaltReq=0 -> Mode=00 next cycle; RunSw=0 with HaltReq=1 -> remains 11.
REQ-031 ARMED, Rst=0 pulsed for 1 cycle before tick -> Mode=00, no CpuEn on following tick, CycleCnt=0.
REQ-032 With STEP_CYCLE_COUNT_EN, preload CycleCnt 0xFFFFFFFE by force, 3 RUN ticks -> CycleCnt=0xFFFFFFFF; without the macro CycleCnt=0 throughout.

Source files
------------

// File: rtl/step_control_if.sv
// Handshake bundle between the single-step controller and its board-side I/O.
// Signal suffixes are from the controller's point of view.
interface step_control_if;
    logic        slow_clk_i;
    logic        run_sw_i;
    logic        step_btn_i;
    logic        halt_req_i;
    logic        cpu_en_o;
    logic [1:0]  mode_o;
    logic [31:0] cycle_cnt_o;

    modport master (
        output slow_clk_i, run_sw_i, step_btn_i, halt_req_i,
        input  cpu_en_o, mode_o, cycle_cnt_o
    );

    modport slave (
        input  slow_clk_i, run_sw_i, step_btn_i, halt_req_i,
        output cpu_en_o, mode_o, cycle_cnt_o
    );
endinterface

// File: rtl/step_control.sv
// Processor clock-enable gate: free-run, single-step and halt control driven by a slow tick.
// Optional macro STEP_CYCLE_COUNT_EN implements the saturating CpuEn pulse counter.
module step_control #(
    parameter int unsigned DebounceVal = 1000000
) (
    input  logic          clk,
    input  logic          rst_n,
    step_control_if.slave bus
);

    localparam int unsigned DbW  = 24;
    localparam int unsigned CycW = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        ARMED  = 2'b10,
        HALTED = 2'b11
    } state_e;

    state_e         state_q, state_d;
    logic           cpu_en_q, cpu_en_d;
    logic           slow_s1_q, slow_s2_q, slow_prev_q, tick_q;
    logic [1:0]     fill_q;
    logic           tick_c;
    logic           btn_s1_q, btn_s2_q, db_q, db_d, db_prev_q;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           step_c;

    // Slow-clock sync and edge detect; prev follows stage 1 until the chain has filled,
    // so a level already high at reset release never looks like a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slow_s1_q   <= 1'b0;
            slow_s2_q   <= 1'b0;
            slow_prev_q <= 1'b0;
            fill_q      <= 2'd0;
            tick_q      <= 1'b0;
        end else begin
            slow_s1_q   <= bus.slow_clk_i;
            slow_s2_q   <= slow_s1_q;
            slow_prev_q <= (fill_q != 2'd2) ? slow_s1_q : slow_s2_q;
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end
            tick_q      <= tick_c;
        end
    end

    assign tick_c = slow_s2_q & ~slow_prev_q;

    // Button debounce: the level follows only after DebounceVal consecutive disagreeing cycles.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        if (btn_s2_q != db_q) begin
            if (db_cnt_q == DbW'(DebounceVal - 1)) begin
                db_d = btn_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1_q  <= 1'b0;
            btn_s2_q  <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            db_cnt_q  <= '0;
        end else begin
            btn_s1_q  <= bus.step_btn_i;
            btn_s2_q  <= btn_s1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            db_cnt_q  <= db_cnt_d;
        end
    end

    assign step_c = db_q & ~db_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cpu_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cpu_en_q <= cpu_en_d;
        end
    end

    // Priority everywhere: halt, then run switch, then step event, then tick.
    always_comb begin
        state_d  = state_q;
        cpu_en_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.halt_req_i) begin
                    state_d = HALTED;
                end else if (bus.run_sw_i) begin
                    state_d = RUN;
                end else if (step_c) begin
                    state_d = ARMED;
                end
            end
            RUN: begin
                if (bus.halt_req_i) begin
                    state_d = HALTED;
                end else begin
                    cpu_en_d = tick_q;
                    if (!bus.run_sw_i) begin
                        state_d = IDLE;
                    end
                end
            end
            ARMED: begin
                if (bus.halt_req_i) begin
                    state_d = HALTED;
                end else if (bus.run_sw_i) begin
                    state_d  = RUN;
                    cpu_en_d = tick_q;
                end else if (tick_q) begin
                    state_d  = IDLE;
                    cpu_en_d = 1'b1;
                end
            end
            HALTED: begin
                if (!bus.run_sw_i && !bus.halt_req_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cpu_en_o = cpu_en_q;
    assign bus.mode_o   = state_q;

`ifdef STEP_CYCLE_COUNT_EN
    logic [CycW-1:0] cycle_cnt_q, cycle_cnt_d;

    // Counts granted steps alongside the CpuEn register; sticks at all-ones.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (cpu_en_d && (cycle_cnt_q != {CycW{1'b1}})) begin
            cycle_cnt_d = cycle_cnt_q + CycW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign bus.cycle_cnt_o = cycle_cnt_q;
`else
    assign bus.cycle_cnt_o = {CycW{1'b0}};
`endif

endmodule

// File: tb/tb_step_control.sv
// Randomised and directed bench for step_control against a latency/priority reference model.
module tb_step_control;

    localparam int unsigned Db = 4;
    localparam logic [1:0] M_IDLE  = 2'b00;
    localparam logic [1:0] M_RUN   = 2'b01;
    localparam logic [1:0] M_ARMED = 2'b10;
    localparam logic [1:0] M_HALT  = 2'b11;
`ifdef STEP_CYCLE_COUNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    step_control_if bus ();

    step_control #(.DebounceVal(Db)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned pulses = 0;
    bit chk_on      = 1'b0;
    bit preload_req = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int unsigned n);
        return CntEn ? 32'(n) : 32'd0;
    endfunction

    // Reference model: a tick is decided 3 edges after the sampled rising edge of SlowClk,
    // a step is a debounced rise seen one edge later, and the mode follows the priority rules.
    bit          slow_h[$];
    bit          btn_h[$];
    int          m_edges;
    logic [1:0]  m_mode;
    bit          m_en;
    logic [31:0] m_cnt;
    bit          m_db;
    bit          m_rise;

    always @(posedge clk or negedge rst_n) begin
        bit tick, step, flip, grant, halt, run;
        if (!rst_n) begin
            slow_h.delete();
            btn_h.delete();
            for (int i = 0; i < 5; i++) slow_h.push_back(1'b0);
            for (int i = 0; i < int'(Db) + 2; i++) btn_h.push_back(1'b0);
            m_edges = 0;
            m_mode  = M_IDLE;
            m_en    = 1'b0;
            m_cnt   = 32'd0;
            m_db    = 1'b0;
            m_rise  = 1'b0;
        end else begin
            halt = bus.halt_req_i;
            run  = bus.run_sw_i;
            slow_h.push_front(bus.slow_clk_i);
            void'(slow_h.pop_back());
            btn_h.push_front(bus.step_btn_i);
            void'(btn_h.pop_back());
            tick = (m_edges >= 4) && slow_h[3] && !slow_h[4];
            step = m_rise;
            flip = 1'b1;
            for (int i = 2; i < int'(Db) + 2; i++) begin
                if (btn_h[i] == m_db) flip = 1'b0;
            end
            m_rise = flip && !m_db;
            if (flip) m_db = !m_db;
            grant = tick && !halt && (m_mode == M_RUN || m_mode == M_ARMED);
            case (m_mode)
                M_IDLE:  m_mode = halt ? M_HALT : run ? M_RUN : step ? M_ARMED : M_IDLE;
                M_RUN:   m_mode = halt ? M_HALT : run ? M_RUN : M_IDLE;
                M_ARMED: m_mode = halt ? M_HALT : run ? M_RUN : tick ? M_IDLE : M_ARMED;
                default: m_mode = (!run && !halt) ? M_IDLE : M_HALT;
            endcase
            m_en = grant;
            if (grant && CntEn && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (preload_req) m_cnt = 32'hFFFF_FFFE;
            if (m_edges < 1000000) m_edges++;
        end
    end

    always @(negedge clk) begin
        if (bus.cpu_en_o === 1'b1) pulses++;
        if (chk_on) begin
            check("cpu_en", 32'(bus.cpu_en_o), 32'(m_en));
            check("mode", 32'(bus.mode_o), 32'(m_mode));
            check("cycle_cnt", bus.cycle_cnt_o, m_cnt);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_mode(input string tag, input logic [1:0] m, input int unsigned budget);
        int unsigned k = 0;
        while (bus.mode_o !== m && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, 32'(bus.mode_o), 32'(m));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned p0;
        int unsigned slow_hold;
        bus.slow_clk_i = 1'b1;
        bus.run_sw_i   = 1'b1;
        bus.step_btn_i = 1'b0;
        bus.halt_req_i = 1'b0;
        #1 rst_n = 1'b0;
        cyc(3);
        check("rst_mode", 32'(bus.mode_o), 32'(M_IDLE));
        check("rst_cpu_en", 32'(bus.cpu_en_o), 32'd0);
        check("rst_cnt", bus.cycle_cnt_o, 32'd0);
        chk_on = 1'b1;

        // SlowClk already high at reset release must not produce a tick.
        p0 = pulses;
        rst_n = 1'b1;
        cyc(12);
        check("no_tick_after_rst", pulses - p0, 0);
        check("run_after_rst", 32'(bus.mode_o), 32'(M_RUN));
        bus.slow_clk_i = 1'b0;
        cyc(4);
        bus.run_sw_i = 1'b0;
        cyc(2);

        // Bouncing button never settles long enough.
        for (int i = 0; i < 10; i++) begin
            bus.step_btn_i = ~bus.step_btn_i;
            cyc(2);
        end
        cyc(8);
        check("bounce_mode", 32'(bus.mode_o), 32'(M_IDLE));

        // Clean press arms; the next tick gives one pulse exactly 3 edges after sampling.
        p0 = pulses;
        bus.step_btn_i = 1'b1;
        cyc(10);
        wait_mode("armed", M_ARMED, 20);
        cyc(1);
        bus.step_btn_i = 1'b0;
        bus.slow_clk_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("step_latency", 32'(bus.cpu_en_o), 32'(k == 3));
        end
        cyc(6);
        bus.slow_clk_i = 1'b0;
        cyc(2);
        check("step_pulses", pulses - p0, 1);
        check("step_mode", 32'(bus.mode_o), 32'(M_IDLE));
        check("step_cnt", bus.cycle_cnt_o, cnt_exp(1));

        // Free run, then halt coincident with the sixth tick.
        pulse_reset();
        p0 = pulses;
        bus.run_sw_i = 1'b1;
        cyc(3);
        for (int i = 0; i < 5; i++) begin
            bus.slow_clk_i = 1'b1;
            cyc(6);
            bus.slow_clk_i = 1'b0;
            cyc(6);
        end
        check("run_pulses", pulses - p0, 5);
        check("run_cnt", bus.cycle_cnt_o, cnt_exp(5));
        bus.slow_clk_i = 1'b1;
        cyc(3);
        bus.halt_req_i = 1'b1;
        cyc(3);
        check("halt_pulses", pulses - p0, 5);
        check("halt_mode", 32'(bus.mode_o), 32'(M_HALT));
        check("halt_cnt", bus.cycle_cnt_o, cnt_exp(5));
        bus.slow_clk_i = 1'b0;
        bus.run_sw_i   = 1'b0;
        cyc(2);
        check("halt_held", 32'(bus.mode_o), 32'(M_HALT));
        bus.halt_req_i = 1'b0;
        @(posedge clk);
        #1;
        check("halt_release", 32'(bus.mode_o), 32'(M_IDLE));
        cyc(2);

        // Reset while armed discards the pending step.
        bus.step_btn_i = 1'b1;
        wait_mode("armed2", M_ARMED, 20);
        cyc(1);
        bus.step_btn_i = 1'b0;
        p0 = pulses;
        rst_n = 1'b0;
        #1;
        check("rst_armed_mode", 32'(bus.mode_o), 32'(M_IDLE));
        cyc(1);
        rst_n = 1'b1;
        cyc(3);
        bus.slow_clk_i = 1'b1;
        cyc(8);
        bus.slow_clk_i = 1'b0;
        cyc(2);
        check("rst_armed_pulses", pulses - p0, 0);
        check("rst_armed_mode2", 32'(bus.mode_o), 32'(M_IDLE));
        check("rst_armed_cnt", bus.cycle_cnt_o, 32'd0);

        // Counter saturation.
        pulse_reset();
        bus.run_sw_i = 1'b1;
        cyc(3);
`ifdef STEP_CYCLE_COUNT_EN
        chk_on = 1'b0;
        preload_req = 1'b1;
        force dut.cycle_cnt_q = 32'hFFFF_FFFE;
        cyc(1);
        release dut.cycle_cnt_q;
        preload_req = 1'b0;
        chk_on = 1'b1;
`endif
        for (int i = 0; i < 3; i++) begin
            bus.slow_clk_i = 1'b1;
            cyc(6);
            bus.slow_clk_i = 1'b0;
            cyc(6);
        end
        check("sat_cnt", bus.cycle_cnt_o, CntEn ? 32'hFFFF_FFFF : 32'd0);
        bus.run_sw_i = 1'b0;
        cyc(2);

        // Random phase: model comparisons run every cycle.
        slow_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc(1);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 799) == 0) rst_n = 1'b0;
            if (slow_hold == 0) begin
                bus.slow_clk_i = ~bus.slow_clk_i;
                slow_hold = $urandom_range(2, 12);
            end else begin
                slow_hold--;
            end
            if ($urandom_range(0, 79) == 0) bus.run_sw_i = ~bus.run_sw_i;
            bus.halt_req_i = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) bus.step_btn_i = ~bus.step_btn_i;
        end
        rst_n = 1'b1;
        cyc(4);
        chk_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
